// File: rtl/tv80_dbg_pkg.sv
// Shared definitions for the TV80 debug register save/restore engine.
package tv80_dbg_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StTxH   = 3'd2,
    StTxL   = 3'd3,
    StRxH   = 3'd4,
    StRxL   = 3'd5,
    StWrite = 3'd6,
    StDone  = 3'd7
  } state_e;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/tv80_reg_xfer_if.sv
// Control, register-file and byte-stream signals of the debug save/restore engine.
interface tv80_reg_xfer_if #(
  parameter int unsigned ADDR_W = 3
) ();
  logic              start;
  logic              mode;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_doh;
  logic [7:0]        reg_dol;
  logic [7:0]        reg_dih;
  logic [7:0]        reg_dil;
  logic              reg_weh;
  logic              reg_wel;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;

  // Debug controller / register file / byte links side
  modport master (
    output start, mode, abort, reg_doh, reg_dol, tx_ready, rx_data, rx_valid,
    input  busy, done, reg_addr, reg_dih, reg_dil, reg_weh, reg_wel, tx_data, tx_valid, rx_ready
  );

  // Engine side
  modport slave (
    input  start, mode, abort, reg_doh, reg_dol, tx_ready, rx_data, rx_valid,
    output busy, done, reg_addr, reg_dih, reg_dil, reg_weh, reg_wel, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/tv80_reg_xfer.sv
// Debug save/restore engine: dumps TV80 register pairs as a byte stream (high byte first)
// or loads a byte stream back into the register file.
module tv80_reg_xfer
  import tv80_dbg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  tv80_reg_xfer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       shadow_q, shadow_d;

  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              rx_ready;
  logic              reg_we;
  logic              done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    reg_we   = 1'b0;
    done     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_d   = '0;
          state_d = (bus.mode == MODE_LOAD) ? StRxH : StFetch;
        end
      end
      StFetch: begin
        shadow_d = {bus.reg_doh, bus.reg_dol};
        state_d  = StTxH;
      end
      StTxH: begin
        tx_valid = 1'b1;
        tx_data  = shadow_q[15:8];
        if (bus.tx_ready) state_d = StTxL;
      end
      StTxL: begin
        tx_valid = 1'b1;
        tx_data  = shadow_q[7:0];
        if (bus.tx_ready) begin
          if (cnt_q == LastIdx) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end
      end
      StRxH: begin
        rx_ready = 1'b1;
        if (bus.rx_valid) begin
          shadow_d[15:8] = bus.rx_data;
          state_d        = StRxL;
        end
      end
      StRxL: begin
        rx_ready = 1'b1;
        if (bus.rx_valid) begin
          shadow_d[7:0] = bus.rx_data;
          state_d       = StWrite;
        end
      end
      StWrite: begin
        reg_we = 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = StRxH;
        end
      end
      StDone: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a start seen in IDLE.
    if (bus.abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done;
  assign bus.reg_addr = (state_q != StIdle) ? cnt_q : '0;
  assign bus.reg_dih  = reg_we ? shadow_q[15:8] : 8'h00;
  assign bus.reg_dil  = reg_we ? shadow_q[7:0] : 8'h00;
  assign bus.reg_weh  = reg_we;
  assign bus.reg_wel  = reg_we;
  assign bus.tx_data  = tx_data;
  assign bus.tx_valid = tx_valid;
  assign bus.rx_ready = rx_ready;

endmodule

// File: tb/tb_tv80_reg_xfer.sv
// Bench for tv80_reg_xfer: table-driven dump/load runs, randomized runs against a
// register-file model, and hand sequences for abort, start-while-busy and reset.
module tb_tv80_reg_xfer;
  import tv80_dbg_pkg::*;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tv80_reg_xfer_if #(.ADDR_W(3)) a ();
  tv80_reg_xfer_if #(.ADDR_W(3)) b ();

  tv80_reg_xfer #(.NUM_REGS(8), .ADDR_W(3)) dut_a (.clk(clk), .reset_n(rst_n), .bus(a));
  tv80_reg_xfer #(.NUM_REGS(2), .ADDR_W(3)) dut_b (.clk(clk), .reset_n(rst_n), .bus(b));

  // Register file seen by instance a, with a bench-side preload port
  logic [7:0] rf_h [8];
  logic [7:0] rf_l [8];
  logic       pl_en;
  logic [2:0] pl_idx;
  logic [7:0] pl_h, pl_l;
  int         wr_cnt = 0;
  int         wr_bad = 0;
  int         done_cnt = 0;

  always @(posedge clk) begin
    if (pl_en) begin
      rf_h[pl_idx] <= pl_h;
      rf_l[pl_idx] <= pl_l;
    end
    if (a.reg_weh) rf_h[a.reg_addr] <= a.reg_dih;
    if (a.reg_wel) rf_l[a.reg_addr] <= a.reg_dil;
    if (a.reg_weh || a.reg_wel) wr_cnt <= wr_cnt + 1;
    if (a.reg_weh != a.reg_wel) wr_bad <= wr_bad + 1;
    if (a.done) done_cnt <= done_cnt + 1;
  end

  assign a.reg_doh = rf_h[a.reg_addr];
  assign a.reg_dol = rf_l[a.reg_addr];
  assign b.reg_doh = 8'h50 + {5'd0, b.reg_addr};
  assign b.reg_dol = 8'h60 + {5'd0, b.reg_addr};

  vec_t       dump_tab [8];
  vec_t       load_tab [8];
  vec_t       cur      [8];
  vec_t       load_in  [8];
  vec_t       model    [8];
  logic [7:0] got_q    [$];
  int         tests = 0;
  int         failed = 0;
  int         lat, f2d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, 32'(a.busy), 0);
    check({name, "_done"}, 32'(a.done), 0);
    check({name, "_tx_valid"}, 32'(a.tx_valid), 0);
    check({name, "_tx_data"}, 32'(a.tx_data), 0);
    check({name, "_rx_ready"}, 32'(a.rx_ready), 0);
    check({name, "_reg_addr"}, 32'(a.reg_addr), 0);
    check({name, "_weh"}, 32'(a.reg_weh), 0);
    check({name, "_wel"}, 32'(a.reg_wel), 0);
    check({name, "_dih"}, 32'(a.reg_dih), 0);
    check({name, "_dil"}, 32'(a.reg_dil), 0);
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      pl_en  = 1'b1;
      pl_idx = 3'(i);
      pl_h   = cur[i].hi;
      pl_l   = cur[i].lo;
      tick();
    end
    pl_en = 1'b0;
    model = cur;
  endtask

  task automatic check_rf(input string name);
    for (int i = 0; i < 8; i++) begin
      check({name, "_rf_hi"}, 32'(rf_h[i]), 32'(model[i].hi));
      check({name, "_rf_lo"}, 32'(rf_l[i]), 32'(model[i].lo));
    end
  endtask

  // Expected dump: every pair of the model in address order, high byte first
  task automatic check_stream(input string name);
    check({name, "_len"}, got_q.size(), 16);
    if (got_q.size() == 16) begin
      for (int i = 0; i < 8; i++) begin
        check({name, "_hi"}, 32'(got_q[2*i]), 32'(model[i].hi));
        check({name, "_lo"}, 32'(got_q[2*i+1]), 32'(model[i].lo));
      end
    end
  endtask

  task automatic do_dump(input int bp_pair, input int bp_len, input bit rnd, input int start_at);
    int cyc, nb, bp_left, d0;
    bit seen;
    got_q.delete();
    lat = -1; f2d = -1; nb = 0; seen = 1'b0; bp_left = bp_len; d0 = done_cnt;
    a.mode = MODE_DUMP; a.start = 1'b1;
    tick();
    a.start = 1'b0;
    cyc = 1;
    while (cyc < 400 && f2d < 0) begin
      if (a.tx_valid && !seen) begin
        seen = 1'b1;
        lat = cyc;
      end
      if (a.done) f2d = cyc - 1;
      a.start = (cyc == start_at);
      a.mode  = (cyc == start_at) ? MODE_LOAD : MODE_DUMP;
      if (a.tx_valid && nb == 2 * bp_pair && bp_left > 0) begin
        a.tx_ready = 1'b0;
        bp_left--;
        check("bp_hold_valid", 32'(a.tx_valid), 1);
        check("bp_hold_data", 32'(a.tx_data), 32'(model[bp_pair].hi));
      end else begin
        a.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (a.tx_valid && a.tx_ready) begin
        got_q.push_back(a.tx_data);
        nb++;
      end
      tick();
      cyc++;
    end
    a.tx_ready = 1'b0; a.start = 1'b0; a.mode = MODE_DUMP;
    check("dump_finished", 32'(f2d >= 0), 1);
    check("dump_busy_after_done", 32'(a.busy), 0);
    check("dump_done_pulses", done_cnt - d0, 1);
  endtask

  task automatic do_load(input int abort_after);
    logic [7:0] q [$];
    int gap, w0, d0, b0, cyc, npairs;
    bit aborted;
    for (int i = 0; i < 8; i++) begin
      q.push_back(load_in[i].hi);
      q.push_back(load_in[i].lo);
    end
    w0 = wr_cnt; d0 = done_cnt; b0 = wr_bad; aborted = 1'b0; cyc = 0;
    gap = $urandom_range(0, 3);
    a.mode = MODE_LOAD; a.start = 1'b1;
    tick();
    a.start = 1'b0;
    while (cyc < 400) begin
      if (a.done) break;
      if (abort_after >= 0 && wr_cnt - w0 == abort_after + 1) begin
        a.abort = 1'b1; a.rx_valid = 1'b0;
        tick();
        a.abort = 1'b0;
        check("abort_busy", 32'(a.busy), 0);
        check("abort_rx_ready", 32'(a.rx_ready), 0);
        aborted = 1'b1;
        break;
      end
      if (q.size() == 0) begin
        a.rx_valid = 1'b0;
      end else if (gap > 0) begin
        a.rx_valid = 1'b0;
        gap--;
      end else begin
        a.rx_valid = 1'b1;
        a.rx_data  = q[0];
        if (a.rx_ready) begin
          void'(q.pop_front());
          gap = $urandom_range(0, 3);
        end
      end
      tick();
      cyc++;
    end
    a.rx_valid = 1'b0;
    npairs = (abort_after >= 0) ? abort_after + 1 : 8;
    if (!aborted) begin
      check("load_done_seen", 32'(a.done), 1);
      tick();
      check("load_busy_after_done", 32'(a.busy), 0);
      check("load_done_pulses", done_cnt - d0, 1);
    end else begin
      tick();
      tick();
      check("abort_no_done", done_cnt - d0, 0);
    end
    check("load_write_pulses", wr_cnt - w0, npairs);
    check("load_we_paired", wr_bad - b0, 0);
    for (int i = 0; i < npairs; i++) model[i] = load_in[i];
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      dump_tab[i].hi = 8'h10 + 8'(i);
      dump_tab[i].lo = 8'h20 + 8'(i);
      load_tab[i].hi = 8'hA0 + 8'(i);
      load_tab[i].lo = 8'hB0 + 8'(i);
    end
    pl_en = 1'b0; pl_idx = 3'd0; pl_h = 8'h00; pl_l = 8'h00;
    a.start = 1'b0; a.mode = MODE_DUMP; a.abort = 1'b0;
    a.tx_ready = 1'b0; a.rx_data = 8'h00; a.rx_valid = 1'b0;
    b.start = 1'b0; b.mode = MODE_DUMP; b.abort = 1'b0;
    b.tx_ready = 1'b0; b.rx_data = 8'h00; b.rx_valid = 1'b0;

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_zero("reset");

    // Plain dump with the sink always ready
    cur = dump_tab;
    preload();
    do_dump(-1, 0, 1'b0, -1);
    check("dump_first_valid_latency", lat, 2);
    check("dump_fetch_to_done", f2d, 24);
    check_stream("dump");

    // Backpressure on the high byte of pair 2
    do_dump(2, 5, 1'b0, -1);
    check_stream("dump_bp");

    // A load request in the middle of a dump is ignored
    do_dump(-1, 0, 1'b0, 7);
    check_stream("dump_start_busy");
    check_rf("dump_start_busy");

    // Load from the table with random gaps
    load_in = load_tab;
    do_load(-1);
    check_rf("load");

    // Abort after pair 3 is written, from a freshly preloaded file
    cur = dump_tab;
    preload();
    do_load(3);
    check_rf("abort");

    // Abort together with start in IDLE keeps the engine idle
    a.start = 1'b1; a.mode = MODE_LOAD; a.abort = 1'b1;
    tick();
    a.start = 1'b0; a.abort = 1'b0;
    check("abort_start_busy", 32'(a.busy), 0);
    tick();
    check("abort_start_busy_later", 32'(a.busy), 0);

    // A fresh start after abort runs to completion
    do_load(-1);
    check_rf("after_abort");

    // Randomized contents and handshakes against the model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        cur[i].hi = 8'($urandom);
        cur[i].lo = 8'($urandom);
        load_in[i].hi = 8'($urandom);
        load_in[i].lo = 8'($urandom);
      end
      preload();
      do_dump(-1, 0, 1'b1, -1);
      check_stream("rnd_dump");
      do_load(-1);
      check_rf("rnd_load");
    end

    // Reset asserted while the low byte of pair 0 is offered
    a.mode = MODE_DUMP; a.start = 1'b1;
    tick();
    a.start = 1'b0;
    tick();
    a.tx_ready = 1'b1;
    tick();
    a.tx_ready = 1'b0;
    check("pre_rst_txl_valid", 32'(a.tx_valid), 1);
    check("pre_rst_txl_data", 32'(a.tx_data), 32'(model[0].lo));
    rst_n = 1'b0;
    tick();
    check_zero("reset_mid");
    rst_n = 1'b1;
    tick();
    check("reset_mid_idle", 32'(a.busy), 0);

    // Two-pair instance
    got_q.delete();
    b.mode = MODE_DUMP; b.start = 1'b1;
    tick();
    b.start = 1'b0;
    b.tx_ready = 1'b1;
    begin
      int cyc;
      int nd;
      cyc = 0;
      nd = 0;
      while (cyc < 50 && nd == 0) begin
        if (b.done) nd++;
        if (b.tx_valid) got_q.push_back(b.tx_data);
        tick();
        cyc++;
      end
      check("small_done", nd, 1);
      check("small_len", got_q.size(), 4);
      if (got_q.size() == 4) begin
        for (int i = 0; i < 2; i++) begin
          check("small_hi", 32'(got_q[2*i]), 32'h50 + i);
          check("small_lo", 32'(got_q[2*i+1]), 32'h60 + i);
        end
      end
      check("small_busy_after", 32'(b.busy), 0);
    end
    b.tx_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tv80_reg_xfer.md
Name: tv80_reg_xfer

Overview:
- Debug save/restore engine for the TV80 register file.
- Dump mode: walks register-file addresses 0..NUM_REGS-1 through one read port and streams each pair out as bytes, high then low, over a valid/ready byte interface.
- Load mode: accepts bytes from a valid/ready byte interface and writes them back through the register-file write port.
- Sits beside the register file, muxed onto its C read port and A write port by the debug controller. It is only active while the core is held.

Parameters:
- NUM_REGS, 8, number of register pairs walked (1..8).
- ADDR_W, 3, register-file address width.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = dump, 1 = load; sampled with start
- abort  in  1  return to IDLE next cycle from any state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- reg_addr  out  ADDR_W  register-file address (drives AddrC for dump, AddrA for load)
- reg_doh  in  8  register-file read data, high byte (async read)
- reg_dol  in  8  register-file read data, low byte
- reg_dih  out  8  write data, high byte
- reg_dil  out  8  write data, low byte
- reg_weh  out  1  write enable, high byte
- reg_wel  out  1  write enable, low byte
- tx_data  out  8  dump byte
- tx_valid  out  1  dump byte valid
- tx_ready  in  1  sink accepts byte
- rx_data  in  8  load byte
- rx_valid  in  1  load byte valid
- rx_ready  out  1  engine accepts byte

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset values: all outputs 0, state IDLE, address counter 0, shadow 0.
- States: IDLE, FETCH, TX_H, TX_L, RX_H, RX_L, WRITE, DONE.
- IDLE:
  - start=1, mode=0 -> FETCH with counter 0.
  - start=1, mode=1 -> RX_H with counter 0.
  - start is ignored in every other state.
- FETCH:
  - reg_addr = counter.
  - 16-bit shadow captures {reg_doh, reg_dol} at the end of the cycle -> TX_H.
- TX_H:
  - tx_valid=1, tx_data = shadow[15:8].
  - Handshake when tx_valid & tx_ready -> TX_L.
- TX_L:
  - tx_data = shadow[7:0].
  - On handshake: if counter = NUM_REGS-1 -> DONE; else counter+1 -> FETCH.
- tx_data is stable while tx_valid is high and not accepted; tx_valid never drops without a handshake, except on abort.
- Dump latency: start at cycle T -> first tx_valid at T+2. With tx_ready held high, one pair per 3 cycles, so 3*NUM_REGS cycles from FETCH to DONE.
- RX_H:
  - rx_ready=1.
  - On rx_valid & rx_ready the byte is latched into the shadow high byte -> RX_L.
- RX_L:
  - rx_ready=1.
  - On handshake the byte is latched into the shadow low byte -> WRITE.
- WRITE:
  - Exactly one cycle: reg_addr = counter, reg_dih/reg_dil = shadow, reg_weh = reg_wel = 1.
  - If counter = NUM_REGS-1 -> DONE; else counter+1 -> RX_H.
- reg_weh/reg_wel are never high outside WRITE.
- DONE: done=1 for one cycle, busy=1 -> IDLE. busy falls the cycle after done.
- abort (any state):
  - Next state IDLE, counter 0.
  - tx_valid, rx_ready and write enables are low from the next cycle.
  - No done pulse.
  - Registers already written stay written.
  - abort in the same cycle as start in IDLE: abort wins, the engine stays IDLE.
- Counter: ADDR_W bits and never exceeds NUM_REGS-1. There is no wrap within one operation.
- reset_n low mid-operation: same effect as abort, plus all outputs forced to reset values.
- reg_addr holds the counter value in all non-IDLE states and is 0 in IDLE.

Decomposition:
- Shared package tv80_dbg_pkg holds:
  - the state encoding constants (IDLE..DONE, 3 bits);
  - MODE_DUMP = 0 and MODE_LOAD = 1.
- There are no sub-modules. The byte handshakes are simple enough to stay inline in the state machine.

Test Plan:
- Dump, tx_ready always 1:
  - Preload pairs 0..7 with {8'h10+i, 8'h20+i}; pulse start with mode=0.
  - Expect 16 bytes: 10,20,11,21,...,17,27.
  - Expect first tx_valid 2 cycles after start and done 24 cycles after FETCH entry.
- Dump with backpressure:
  - Drive tx_ready = 0 for 5 cycles on the TX_H of pair 2.
  - Expect tx_data held at 8'h12 with tx_valid high, then the stream continues unchanged.
- Load:
  - Stream bytes A0,B0,A1,B1,...,A7,B7 with rx_valid gaps of 0 to 3 cycles.
  - Expect each pair i = {8'hA0+i, 8'hB0+i}.
  - Expect reg_weh/reg_wel high exactly 8 single cycles, then one done pulse.
- Abort during load:
  - Assert abort after pair 3 is written.
  - Expect pairs 0..3 updated, pairs 4..7 unchanged, no done, busy low the next cycle.
  - A fresh start is then accepted.
- Start while busy:
  - Pulse start (mode=1) mid-dump.
  - Expect it to be ignored and the dump to complete with 16 bytes.
- Reset mid-dump:
  - Drive reset_n low for 1 cycle during TX_L.
  - Expect all outputs 0 on the next edge and state IDLE.
- NUM_REGS = 2 instance:
  - Dump emits 4 bytes, then done.
